alu_op_issuer: RTL

- Upstream stage for the 4-bit ALU (operands a/b, 3-bit select s, registered 8-bit result o).
- Accepts operation commands through a valid/ready queue and drives one operation at a time onto the ALU inputs.
- Holds the ALU inputs stable for a fixed settle window, samples the ALU result, and returns it on a valid/ready result port.
- Replaces hand-timed operand sequencing with a flow-controlled stage.

---
 rtl/alu_op_issuer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/alu_op_issuer.sv
// Flow-controlled issue stage for the registered 4-bit ALU: queues commands, holds operands for a settle window, returns sampled results.
// Optional ops_done result counter enabled by defining ALU_ISSUE_COUNT_EN.
module alu_op_issuer #(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  input  logic [2:0] cmd_s,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_s,
  input  logic [7:0] alu_o,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic [2:0] res_s,
  output logic       busy
`ifdef ALU_ISSUE_COUNT_EN
  ,
  output logic [15:0] ops_done
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int HC_W  = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, HOLD, RESULT} state_e;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] s;
  } cmd_t;

  cmd_t             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  state_e           state_q, state_d;
  logic [HC_W-1:0]  hold_q, hold_d;
  logic [3:0]       alu_a_q, alu_a_d;
  logic [3:0]       alu_b_q, alu_b_d;
  logic [2:0]       alu_s_q, alu_s_d;
  logic             res_valid_q, res_valid_d;
  logic [7:0]       res_data_q, res_data_d;
  logic [2:0]       res_s_q, res_s_d;

  logic push;
  logic pop;
  logic handshake;
  cmd_t head;

  // Readiness comes from the registered count only, so a pop cannot open a slot for a push on the same edge.
  assign cmd_ready = (count_q != CNT_W'(DEPTH));
  assign push      = cmd_valid & cmd_ready;
  assign head      = mem_q[rd_ptr_q];

  // NOTE: storage has no reset; emptiness is defined by the pointers and count, so stale entries are never read.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= '{a: cmd_a, b: cmd_b, s: cmd_s};
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_s_d     = alu_s_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_s_d     = res_s_q;
    pop         = 1'b0;
    handshake   = 1'b0;

    case (state_q)
      IDLE: begin
        if (count_q != '0) pop = 1'b1;
      end
      HOLD: begin
        hold_d = hold_q - HC_W'(1);
        if (hold_q == HC_W'(1)) begin
          res_data_d  = alu_o;
          res_s_d     = alu_s_q;
          res_valid_d = 1'b1;
          state_d     = RESULT;
        end
      end
      RESULT: begin
        if (res_ready) begin
          handshake   = 1'b1;
          res_valid_d = 1'b0;
          if (count_q != '0) pop = 1'b1;
          else               state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // alu_s doubles as the held select, since operands only change on a pop.
    if (pop) begin
      alu_a_d = head.a;
      alu_b_d = head.b;
      alu_s_d = head.s;
      hold_d  = HC_W'(HOLD_CYCLES);
      state_d = HOLD;
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= IDLE;
      hold_q      <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_s_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_s_q     <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      hold_q      <= hold_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_s_q     <= alu_s_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_s_q     <= res_s_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_s     = alu_s_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_s     = res_s_q;
  assign busy      = (count_q != '0) || (state_q != IDLE);

`ifdef ALU_ISSUE_COUNT_EN
  logic [15:0] ops_done_q, ops_done_d;

  always_comb begin
    ops_done_d = ops_done_q;
    if (handshake) ops_done_d = ops_done_q + 16'd1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) ops_done_q <= '0;
    else          ops_done_q <= ops_done_d;
  end

  assign ops_done = ops_done_q;
`else
  logic unused_handshake;
  assign unused_handshake = handshake;
`endif

endmodule
